// File: rtl/pipeline_pkg.sv
// Shared definitions for the 8-bit pipelined core: datapath widths, the
// canonical NOP encoding and the fetch-stage state type.
package pipeline_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] NOP = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } if_state_t;

    // Sequential instruction address; wraps modulo 2**PC_W with no carry out.
    function automatic logic [PC_W-1:0] pc_step(input logic [PC_W-1:0] pc);
        return pc + PC_W'(2);
    endfunction

endpackage

// File: rtl/pipeline_if_if.sv
// Instruction-memory request/ready handshake between the fetch stage
// (master) and the instruction memory (slave).
interface pipeline_if_if #(
    parameter int DATA_W = pipeline_pkg::INSTR_W
);

    logic                          imem_req;
    logic [pipeline_pkg::PC_W-1:0] imem_addr;
    logic                          imem_ready;
    logic [DATA_W-1:0]             imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/pipeline_if.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests,
// registers each fetched instruction with its link value (PC+2) into the
// IF/ID boundary, parks one instruction in a hold buffer while ID is stalled,
// and redirects on taken branches from EX.
module pipeline_if #(
    parameter logic [pipeline_pkg::PC_W-1:0] RESET_PC = 8'h00,
    parameter int                            INSTR_W  = pipeline_pkg::INSTR_W,
    parameter logic [INSTR_W-1:0]            NOP      = pipeline_pkg::NOP
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          br_taken,
    input  logic [pipeline_pkg::PC_W-1:0] br_target,
    pipeline_if_if.master                 imem,
    output logic [INSTR_W-1:0]            if_instr,
    output logic [pipeline_pkg::PC_W-1:0] if_pc2,
    output logic                          if_valid
);
    import pipeline_pkg::*;

    if_state_t          state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [PC_W-1:0]    if_pc2_q, if_pc2_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic [PC_W-1:0]    hold_pc2_q, hold_pc2_d;

    logic               imem_accept;
    logic [PC_W-1:0]    pc_plus2;
    logic               unused_br_target_lsb;

    // Branch targets are halfword aligned; the LSB is deliberately dropped.
    assign unused_br_target_lsb = br_target[0];

    // Requests only from REQ, and never in a cycle that is being redirected,
    // so a branch cannot race a stale fetch into the pipeline.
    assign imem.imem_req  = (state_q == REQ) && !br_taken;
    assign imem.imem_addr = pc_q;
    assign imem_accept    = imem.imem_req && imem.imem_ready;
    assign pc_plus2       = pc_step(pc_q);

    assign if_instr = if_instr_q;
    assign if_pc2   = if_pc2_q;
    assign if_valid = if_valid_q;

    // Next-state decision; load priority is br_taken > stall > accept.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        if_instr_d   = if_instr_q;
        if_pc2_d     = if_pc2_q;
        if_valid_d   = if_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc2_d   = hold_pc2_q;

        if (br_taken) begin
            // Flush IF/ID and the hold buffer; any response this cycle is dropped.
            state_d      = REQ;
            pc_d         = {br_target[PC_W-1:1], 1'b0};
            if_instr_d   = NOP;
            if_valid_d   = 1'b0;
            hold_instr_d = NOP;
            hold_pc2_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = REQ;
                end
                REQ: begin
                    if (imem_accept) begin
                        pc_d = pc_plus2;
                        if (!stall || !if_valid_q) begin
                            if_instr_d = imem.imem_rdata;
                            if_pc2_d   = pc_plus2;
                            if_valid_d = 1'b1;
                        end else begin
                            // ID still owns the current output: park the new one.
                            hold_instr_d = imem.imem_rdata;
                            hold_pc2_d   = pc_plus2;
                            state_d      = HOLD;
                        end
                    end else if (!stall) begin
                        if_instr_d = NOP;
                        if_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_instr_d   = hold_instr_q;
                        if_pc2_d     = hold_pc2_q;
                        if_valid_d   = 1'b1;
                        hold_instr_d = NOP;
                        hold_pc2_d   = '0;
                        state_d      = REQ;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and IF/ID registers; rst wins over everything including br_taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            if_instr_q   <= NOP;
            if_pc2_q     <= '0;
            if_valid_q   <= 1'b0;
            hold_instr_q <= NOP;
            hold_pc2_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_instr_q   <= if_instr_d;
            if_pc2_q     <= if_pc2_d;
            if_valid_q   <= if_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc2_q   <= hold_pc2_d;
        end
    end

endmodule

// File: tb/tb_pipeline_if.sv
// Bench for the fetch stage. The reference model is a queue of fetched,
// not-yet-consumed instructions: an accepted fetch is pushed with its link
// value, ID consumes the head on every unstalled cycle, a taken branch or
// reset empties it. The IF/ID output must always present the queue head.
module tb_pipeline_if;
    import pipeline_pkg::*;

    localparam logic [7:0] RST_PC = 8'h00;

    typedef struct packed {
        logic [15:0] instr;
        logic [7:0]  pc2;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [7:0]  br_target;
    logic [15:0] if_instr;
    logic [7:0]  if_pc2;
    logic        if_valid;

    pipeline_if_if imem ();

    pipeline_if #(.RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .imem      (imem.master),
        .if_instr  (if_instr),
        .if_pc2    (if_pc2),
        .if_valid  (if_valid)
    );

    // Second instance starting near the top of the address space (wrap check).
    logic        rst2;
    logic        stall2 = 1'b0;
    logic        br2 = 1'b0;
    logic [7:0]  tgt2 = 8'h00;
    logic [15:0] if_instr2;
    logic [7:0]  if_pc22;
    logic        if_valid2;

    pipeline_if_if imem2 ();
    assign imem2.imem_ready = 1'b1;
    assign imem2.imem_rdata = {8'hA5, imem2.imem_addr};

    pipeline_if #(.RESET_PC(8'hFC)) dut2 (
        .clk       (clk),
        .rst       (rst2),
        .stall     (stall2),
        .br_taken  (br2),
        .br_target (tgt2),
        .imem      (imem2.master),
        .if_instr  (if_instr2),
        .if_pc2    (if_pc22),
        .if_valid  (if_valid2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;
    bit done     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit s, input bit b, input logic [7:0] t, input bit rdy);
        @(negedge clk);
        rst             = r;
        stall           = s;
        br_taken        = b;
        br_target       = t;
        imem.imem_ready = rdy;
        imem.imem_rdata = 16'($urandom);
    endtask

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin
        rst             = 1'b1;
        stall           = 1'b0;
        br_taken        = 1'b0;
        br_target       = 8'h00;
        imem.imem_ready = 1'b0;
        imem.imem_rdata = 16'h0000;
        repeat (2) @(posedge clk);
        started = 1'b1;
        // Streaming with memory always ready.
        repeat (8) drive(0, 0, 0, 8'h00, 1);
        // Stall across an accepted fetch, then release.
        repeat (3) drive(0, 1, 0, 8'h00, 1);
        repeat (4) drive(0, 0, 0, 8'h00, 1);
        // Taken branch to an odd target while a fetch is accepted.
        drive(0, 0, 1, 8'h41, 1);
        repeat (4) drive(0, 0, 0, 8'h00, 1);
        // Memory not ready for four cycles.
        repeat (4) drive(0, 0, 0, 8'h00, 0);
        repeat (3) drive(0, 0, 0, 8'h00, 1);
        // Enter HOLD, then reset together with a branch.
        repeat (2) drive(0, 1, 0, 8'h00, 1);
        drive(1, 1, 1, 8'h80, 1);
        repeat (4) drive(0, 0, 0, 8'h00, 1);
        // Randomized traffic.
        repeat (3000) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 99) < 8,
                  8'($urandom),
                  $urandom_range(0, 9) < 7);
        end
        repeat (3) drive(0, 0, 0, 8'h00, 1);
        done = 1'b1;
        @(negedge clk);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Monitor and scoreboard for the main instance.
    initial begin
        ent_t        fifo[$];
        logic [7:0]  m_pc;
        bit          m_idle;
        bit          exp_req;
        ent_t        head;
        m_pc   = RST_PC;
        m_idle = 1'b1;
        wait (started);
        while (!done) begin
            @(negedge clk);
            #2;
            check("if_valid", {31'd0, if_valid}, {31'd0, fifo.size() > 0});
            if (fifo.size() > 0) begin
                head = fifo[0];
                check("if_instr", {16'd0, if_instr}, {16'd0, head.instr});
                check("if_pc2", {24'd0, if_pc2}, {24'd0, head.pc2});
            end else begin
                check("if_instr_nop", {16'd0, if_instr}, {16'd0, NOP});
            end
            if (m_idle) check("if_pc2_reset", {24'd0, if_pc2}, 32'd0);
            exp_req = !br_taken && !m_idle && (fifo.size() < 2);
            check("imem_req", {31'd0, imem.imem_req}, {31'd0, exp_req});
            if (exp_req) check("imem_addr", {24'd0, imem.imem_addr}, {24'd0, m_pc});

            if (rst) begin
                fifo.delete();
                m_pc   = RST_PC;
                m_idle = 1'b1;
            end else if (br_taken) begin
                fifo.delete();
                m_pc   = {br_target[7:1], 1'b0};
                m_idle = 1'b0;
            end else begin
                if (fifo.size() > 0 && !stall) begin
                    head = fifo.pop_front();
                    $display("txn: consumed instr=%h pc2=%h", head.instr, head.pc2);
                end
                if (exp_req && imem.imem_ready) begin
                    fifo.push_back({imem.imem_rdata, 8'(m_pc + 8'd2)});
                    m_pc = 8'(m_pc + 8'd2);
                end
                m_idle = 1'b0;
            end
        end
    end

    // Directed wrap check on the second instance: link values FE, 00, 02.
    initial begin
        logic [7:0] exp_pc2;
        logic [7:0] exp_addr;
        rst2 = 1'b1;
        repeat (3) @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);
        #3;
        check("wrap_first_cycle_valid", {31'd0, if_valid2}, 32'd0);
        check("wrap_first_req", {31'd0, imem2.imem_req}, 32'd1);
        check("wrap_first_addr", {24'd0, imem2.imem_addr}, 32'h0000_00FC);
        exp_addr = 8'hFC;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #3;
            exp_pc2 = 8'(exp_addr + 8'd2);
            check("wrap_valid", {31'd0, if_valid2}, 32'd1);
            check("wrap_pc2", {24'd0, if_pc22}, {24'd0, exp_pc2});
            check("wrap_instr", {16'd0, if_instr2}, {16'd0, 8'hA5, exp_addr});
            $display("txn: wrap instance instr=%h pc2=%h", if_instr2, if_pc22);
            exp_addr = exp_pc2;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipeline_if.md
# pipeline_if

Instruction-fetch stage of the 8-bit pipelined core, directly upstream of the ID stage.
- Owns the program counter and drives the instruction-memory request/ready handshake.
- Registers each fetched 16-bit instruction with its PC+2 (link value) into the IF/ID boundary.
- Honours hazard-unit stalls with a one-entry hold buffer.
- Redirects on taken branches reported by EX.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset
- INSTR_W, 16, instruction width in bits
- NOP, 16'h0000, value driven on if_instr while invalid/flushed
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hazard unit: hold IF/ID outputs this cycle
- br_taken  in  1  EX: branch/brx taken this cycle
- br_target  in  8  EX: redirect address (bit 0 ignored)
- imem_req  out  1  fetch request valid
- imem_addr  out  8  fetch address (= PC register)
- imem_ready  in  1  memory accepts request; imem_rdata valid same cycle
- imem_rdata  in  INSTR_W  fetched instruction
- if_instr  out  INSTR_W  instruction to ID
- if_pc2  out  8  address of fetched instruction + 2
- if_valid  out  1  if_instr/if_pc2 hold a real instruction

## Operation
- States: IDLE, REQ, HOLD.
- Reset: PC=RESET_PC, state=IDLE, if_instr=NOP, if_pc2=0, if_valid=0, hold buffer empty, imem_req=0.
- IDLE: imem_req=0; unconditionally → REQ next cycle.
- REQ: imem_req = !br_taken; imem_addr=PC. Accept = imem_req && imem_ready.
  - Accept and output free (!stall || !if_valid): if_instr←imem_rdata, if_pc2←PC+2, if_valid←1, PC←PC+2; stay REQ.
  - Accept and stall && if_valid: buffer←{imem_rdata, PC+2}, PC←PC+2; outputs unchanged → HOLD.
  - No accept: stall → outputs held; !stall → if_valid←0, if_instr←NOP (bubble).
- HOLD: imem_req=0; stall → hold everything; !stall → outputs←buffer, if_valid←1, buffer cleared → REQ.
- br_taken overrides everything, stall included:
  - PC←{br_target[7:1],1'b0}, if_valid←0, if_instr←NOP, buffer discarded → REQ.
  - A response arriving that cycle is ignored.
- Arithmetic: 8-bit modulo; PC 8'hFE + 2 = 8'h00, so if_pc2 wraps to 8'h00 with no flag.
- Stalled outputs are bit-stable, including if_pc2 and NOP on invalid.
- rst mid-transaction: pending request abandoned, all state per reset values; rst has priority over br_taken.

## Timing
- Fetch-to-output latency: 1 cycle (accept in cycle n → if_valid in n+1).
- Throughput: 1 instruction/cycle with imem_ready held high.
- After rst deasserts: IDLE in cycle 0, first request in cycle 1, first if_valid=1 in cycle 2.
- br_taken in cycle n: request to br_target issued in cycle n+1; its instruction valid in n+2 at the earliest.
- Stall release from HOLD: buffered instruction appears the next cycle; new request issued in the same cycle as the buffer is presented.
- No combinational path from imem_rdata to any output; imem_req depends combinationally on state and br_taken only.

## Structure
- Shared package pipeline_pkg:
  - INSTR_W and NOP constants.
  - if_state_t enum (IDLE, REQ, HOLD).
  - PC width constant (8), also used by the ID/EX stages.
- Single module, no sub-modules. Hold buffer and output register stay inline, since their load priority (br_taken > stall > accept) is one decision.

## Test plan
- Reset then imem_ready=1 constant, rdata=addr-derived: if_valid rises cycle 2; if_pc2 sequence 02,04,06; if_instr matches addresses 00,02,04.
- stall high 3 cycles while a fetch is accepted: outputs frozen; buffer holds next instr; imem_req=0 in HOLD; on release buffered instr appears, then fetch resumes at buffered PC+2 with no loss or duplicate.
- br_taken with br_target=8'h41 during accepted fetch: response discarded; if_valid=0 next cycle; next imem_addr=8'h40; if_pc2=8'h42 on its delivery.
- imem_ready low 4 cycles: imem_req stays high with stable imem_addr; if_valid=0 bubbles; no PC advance.
- Start at RESET_PC=8'hFC: if_pc2 sequence FE,00,02 (wrap).
- rst asserted while in HOLD with br_taken also high: next cycle all outputs at reset values, PC=RESET_PC, state IDLE.
